alu_ctrl_seq: RTL

Parametrised successor to the EX-stage ALU control decoder. Decodes ALUOp/Function into a widened ALU operation code plus JR, HI/LO-move and multiply/divide controls, registers the result as one pipeline stage, and sequences multi-cycle MULT/DIV operations with a fixed-latency busy counter that stalls the front of the pipe. Sits between the ID/EX register and the ALU/MDU datapath.

---
 rtl/alu_ctrl_pkg.sv | 66 ++++++
 rtl/alu_ctrl_seq_mdu_seq.sv | 95 +++++++++
 rtl/alu_ctrl_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the EX-stage ALU control decoder.
//   - ALU operation codes driven on ALUControl
//   - main-decoder ALUOp classes and R-type funct codes
//   - MDU operation and mfhi/mflo encodings
//   - MDU sequencer state type
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_NOR = 4'd5,
    ALU_XOR = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9
  } alu_op_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  localparam logic [1:0] MFHILO_NONE = 2'b00;
  localparam logic [1:0] MFHILO_LO   = 2'b01;
  localparam logic [1:0] MFHILO_HI   = 2'b10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_mdu_seq.sv
// mdu_seq: fixed-latency multiply/divide sequencer.
//   On i_start (only honoured in IDLE) the op is latched, a busy count is
//   loaded with MUL_LAT or DIV_LAT, and the FSM sits in BUSY until the
//   cycle where the count reaches 1.
//   Build option ALUCTRL_DIV_EN: when undefined only MUL_LAT is used.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_start       accepted MDU instruction this cycle
//   i_op          MDU op of the accepted instruction
//   o_start       one-cycle start pulse (first busy cycle)
//   o_busy        sequence in progress
//   o_hilo_we     one-cycle HI/LO write strobe (last busy cycle)
//   o_op          op of the current/last sequence
module mdu_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [1:0] i_op,
  output logic       o_start,
  output logic       o_busy,
  output logic       o_hilo_we,
  output logic [1:0] o_op
);

  localparam int unsigned MAX_LAT = max_u(MUL_LAT, DIV_LAT);
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;
  logic             r_busy;
  logic             r_hilo_we;
  mdu_op_e          r_op;
  logic [CNT_W-1:0] w_lat;

`ifdef ALUCTRL_DIV_EN
  assign w_lat = i_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
`else
  assign w_lat = CNT_W'(MUL_LAT);
`endif

  // Strobes are registered: hilo_we is raised on the edge entering the
  // count==1 cycle, or directly at start when the latency is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= MDU_IDLE;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_hilo_we <= 1'b0;
      r_op      <= MDU_MULT;
    end else begin
      r_start   <= 1'b0;
      r_hilo_we <= 1'b0;
      case (r_state)
        MDU_IDLE: begin
          if (i_start) begin
            r_state   <= MDU_BUSY;
            r_cnt     <= w_lat;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
            r_op      <= mdu_op_e'(i_op);
            r_hilo_we <= (w_lat == CNT_W'(1));
          end
        end
        MDU_BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt     <= r_cnt - CNT_W'(1);
            r_hilo_we <= (r_cnt == CNT_W'(2));
          end
        end
        default: begin
          r_state <= MDU_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_start   = r_start;
  assign o_busy    = r_busy;
  assign o_hilo_we = r_hilo_we;
  assign o_op      = r_op;

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: EX-stage ALU control decoder with one registered stage and
// a fixed-latency MULT/DIV sequencer that stalls the front of the pipe.
// Build option ALUCTRL_DIV_EN: enables DIV/DIVU decode (uses DIV_LAT);
// otherwise those functs decode as illegal.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   in_valid       instruction offered
//   ALUOp          main-decoder class (00 add, 01 sub, 11 or, 10 R-type)
//   Function       R-type funct field
//   flush          kill offered instruction and registered output
//   ALUControl     registered ALU op code
//   JRControl      registered jr flag
//   mfhilo         registered mfhi(10)/mflo(01)
//   illegal        registered unrecognised-funct flag
//   out_valid      registered outputs meaningful
//   mdu_start      MDU start pulse
//   mdu_op         MDU operation, held through busy
//   mdu_busy       MDU sequence in progress
//   hilo_we        HI/LO write strobe
//   stall          upstream hold, equals mdu_busy
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 4,
  parameter int unsigned MUL_LAT   = 4,
  parameter int unsigned DIV_LAT   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [1:0]           ALUOp,
  input  logic [5:0]           Function,
  input  logic                 flush,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 JRControl,
  output logic [1:0]           mfhilo,
  output logic                 illegal,
  output logic                 out_valid,
  output logic                 mdu_start,
  output logic [1:0]           mdu_op,
  output logic                 mdu_busy,
  output logic                 hilo_we,
  output logic                 stall
);

  alu_op_e    w_alu;
  logic       w_jr;
  logic [1:0] w_mfhilo;
  logic       w_illegal;
  logic       w_mdu_req;
  logic [1:0] w_mdu_op;
  logic       w_accept;
  logic       w_busy;

  alu_op_e    r_alu;
  logic       r_jr;
  logic [1:0] r_mfhilo;
  logic       r_illegal;
  logic       r_valid;

  assign w_accept = in_valid && !w_busy && !flush;

  always_comb begin
    w_alu     = ALU_ADD;
    w_jr      = 1'b0;
    w_mfhilo  = MFHILO_NONE;
    w_illegal = 1'b0;
    w_mdu_req = 1'b0;
    w_mdu_op  = MDU_MULT;
    case (ALUOp)
      ALUOP_ADD: w_alu = ALU_ADD;
      ALUOP_SUB: w_alu = ALU_SUB;
      ALUOP_OR:  w_alu = ALU_OR;
      default: begin
        case (Function)
          FN_ADD, FN_ADDU: w_alu = ALU_ADD;
          FN_SUB, FN_SUBU: w_alu = ALU_SUB;
          FN_AND:          w_alu = ALU_AND;
          FN_OR:           w_alu = ALU_OR;
          FN_XOR:          w_alu = ALU_XOR;
          FN_NOR:          w_alu = ALU_NOR;
          FN_SLT:          w_alu = ALU_SLT;
          FN_SLL:          w_alu = ALU_SLL;
          FN_SRL:          w_alu = ALU_SRL;
          FN_SRA:          w_alu = ALU_SRA;
          FN_JR:           w_jr = 1'b1;
          FN_MFHI:         w_mfhilo = MFHILO_HI;
          FN_MFLO:         w_mfhilo = MFHILO_LO;
          FN_MULT: begin
            w_mdu_req = 1'b1;
            w_mdu_op  = MDU_MULT;
          end
          FN_MULTU: begin
            w_mdu_req = 1'b1;
            w_mdu_op  = MDU_MULTU;
          end
`ifdef ALUCTRL_DIV_EN
          FN_DIV: begin
            w_mdu_req = 1'b1;
            w_mdu_op  = MDU_DIV;
          end
          FN_DIVU: begin
            w_mdu_req = 1'b1;
            w_mdu_op  = MDU_DIVU;
          end
`endif
          default:         w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Non-accepted cycles (bubble, stall or flush) clear every decode field.
  always_ff @(posedge clk) begin
    if (reset || !w_accept) begin
      r_alu     <= ALU_ADD;
      r_jr      <= 1'b0;
      r_mfhilo  <= MFHILO_NONE;
      r_illegal <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_alu     <= w_alu;
      r_jr      <= w_jr;
      r_mfhilo  <= w_mfhilo;
      r_illegal <= w_illegal;
      r_valid   <= 1'b1;
    end
  end

  mdu_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu_seq (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_accept && w_mdu_req),
    .i_op      (w_mdu_op),
    .o_start   (mdu_start),
    .o_busy    (w_busy),
    .o_hilo_we (hilo_we),
    .o_op      (mdu_op)
  );

  assign ALUControl = ALUCTRL_W'(r_alu);
  assign JRControl  = r_jr;
  assign mfhilo     = r_mfhilo;
  assign illegal    = r_illegal;
  assign out_valid  = r_valid;
  assign mdu_busy   = w_busy;
  assign stall      = w_busy;

endmodule
